// File: rtl/bitop_pkg.sv
// Shared opcodes, FSM state type and width helpers for the bit-manipulation unit.
package bitop_pkg;

  localparam logic [2:0] OpParity   = 3'b000;
  localparam logic [2:0] OpRotr     = 3'b001;
  localparam logic [2:0] OpRotl     = 3'b010;
  localparam logic [2:0] OpPopcount = 3'b011;
  localparam logic [2:0] OpClz      = 3'b100;
  localparam logic [2:0] OpCtz      = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Rotate-amount width.
  function automatic int unsigned shw(int unsigned data_width);
    return $clog2(data_width);
  endfunction

  // Count width: must hold the value data_width itself.
  function automatic int unsigned cntw(int unsigned data_width);
    return $clog2(data_width) + 1;
  endfunction

  // Chunk-index width, kept at least one bit wide.
  function automatic int unsigned idxw(int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/bitop_chunk.sv
// Combinational per-slice statistics: popcount, XOR, leading/trailing zeros, nonzero flag.
module bitop_chunk #(
  parameter int unsigned CHUNK_WIDTH = 64
) (
  input  logic [CHUNK_WIDTH-1:0]       slice_i,
  output logic [$clog2(CHUNK_WIDTH):0] pop_o,
  output logic                         xor_o,
  output logic [$clog2(CHUNK_WIDTH):0] lz_o,
  output logic [$clog2(CHUNK_WIDTH):0] tz_o,
  output logic                         nz_o
);

  localparam int unsigned CntW = $clog2(CHUNK_WIDTH) + 1;
  localparam logic [CntW-1:0] One = 1;

  // A zero slice yields CHUNK_WIDTH for both zero counts.
  always_comb begin
    logic seen_hi;
    logic seen_lo;
    pop_o   = '0;
    lz_o    = '0;
    tz_o    = '0;
    seen_hi = 1'b0;
    seen_lo = 1'b0;
    for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
      if (slice_i[i]) begin
        pop_o   = pop_o + One;
        seen_hi = 1'b1;
      end else if (!seen_hi) begin
        lz_o = lz_o + One;
      end
    end
    for (int j = 0; j < CHUNK_WIDTH; j++) begin
      if (slice_i[j]) begin
        seen_lo = 1'b1;
      end else if (!seen_lo) begin
        tz_o = tz_o + One;
      end
    end
    xor_o = ^slice_i;
    nz_o  = |slice_i;
  end

endmodule

// File: rtl/bitop_unit.sv
// Handshaked bit-manipulation unit: iterative count ops over slices, single-cycle rotates.
module bitop_unit
  import bitop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned CHUNK_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam int unsigned Shw       = shw(DATA_WIDTH);
  localparam int unsigned CntW      = cntw(DATA_WIDTH);
  localparam int unsigned NChunk    = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned IdxW      = idxw(NChunk);
  localparam int unsigned ChunkCntW = $clog2(CHUNK_WIDTH) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);
  localparam logic [IdxW-1:0] OneIdx  = 1;

  state_e                state_q, state_d;
  logic [2:0]            opcode_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [Shw-1:0]        b_q;
  logic [CntW-1:0]       acc_q, acc_d, acc_step;
  logic [IdxW-1:0]       idx_q, idx_d, sel;
  logic                  found_q, found_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_err_q, out_err_d;

  logic [NChunk-1:0][CHUNK_WIDTH-1:0] slices;
  logic [ChunkCntW-1:0] chunk_pop, chunk_lz, chunk_tz;
  logic                 chunk_xor, chunk_nz;
  logic [2*DATA_WIDTH-1:0] dbl_r, dbl_l;
  logic                  is_count, accept;

  assign in_ready  = (state_q == StIdle) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

  assign is_count = (opcode_q == OpParity) || (opcode_q == OpPopcount) ||
                    (opcode_q == OpClz) || (opcode_q == OpCtz);

  // CLZ walks from the MSB chunk down; all other count ops walk up from chunk 0.
  assign slices = a_q;
  assign sel    = (opcode_q == OpClz) ? (LastIdx - idx_q) : idx_q;

  bitop_chunk #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_chunk (
    .slice_i (slices[sel]),
    .pop_o   (chunk_pop),
    .xor_o   (chunk_xor),
    .lz_o    (chunk_lz),
    .tz_o    (chunk_tz),
    .nz_o    (chunk_nz)
  );

  // Barrel rotate via a doubled operand.
  assign dbl_r = {a_q, a_q} >> b_q;
  assign dbl_l = {a_q, a_q} << b_q;

  // Per-chunk accumulator update; zero counts freeze once a one has been seen.
  always_comb begin
    acc_step = acc_q;
    case (opcode_q)
      OpParity:   acc_step = {acc_q[CntW-1:1], acc_q[0] ^ chunk_xor};
      OpPopcount: acc_step = acc_q + CntW'(chunk_pop);
      OpClz:      acc_step = found_q ? acc_q : acc_q + CntW'(chunk_lz);
      OpCtz:      acc_step = found_q ? acc_q : acc_q + CntW'(chunk_tz);
      default:    acc_step = acc_q;
    endcase
  end

  // FSM next state and result formation.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    found_d    = found_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          acc_d   = '0;
          idx_d   = '0;
          found_d = 1'b0;
        end
      end
      StRun: begin
        if (is_count) begin
          acc_d   = acc_step;
          found_d = found_q | chunk_nz;
          idx_d   = idx_q + OneIdx;
          if (idx_q == LastIdx) begin
            state_d    = StDone;
            out_data_d = DATA_WIDTH'(acc_step);
            out_err_d  = 1'b0;
          end
        end else begin
          state_d = StDone;
          case (opcode_q)
            OpRotr: begin
              out_data_d = dbl_r[DATA_WIDTH-1:0];
              out_err_d  = 1'b0;
            end
            OpRotl: begin
              out_data_d = dbl_l[2*DATA_WIDTH-1:DATA_WIDTH];
              out_err_d  = 1'b0;
            end
            default: begin
              out_data_d = '0;
              out_err_d  = 1'b1;
            end
          endcase
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      idx_q      <= '0;
      found_q    <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  // Operand capture, only on an accepted transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (accept) begin
      opcode_q <= opcode;
      a_q      <= A_in;
      b_q      <= B_in[Shw-1:0];
    end
  end

endmodule

// File: tb/tb_bitop_unit.sv
// Directed self-checking bench for bitop_unit at default widths.
module tb_bitop_unit;

  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [DW-1:0] A_in;
  logic [DW-1:0] B_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  int errors = 0;
  int checks = 0;

  bitop_unit #(
    .DATA_WIDTH  (256),
    .CHUNK_WIDTH (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction, measure latency, check result, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_data,
                        input logic exp_err, input int exp_lat);
    int lat;
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_ready"}, DW'(in_ready), DW'(1));
    in_valid = 1'b1;
    opcode   = op;
    A_in     = a;
    B_in     = b;
    step();
    in_valid = 1'b0;
    // Scramble inputs to show they were captured on acceptance.
    A_in     = ~a;
    B_in     = b + 1;
    opcode   = 3'b111;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, DW'(lat), DW'(exp_lat));
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_err"}, DW'(out_err), DW'(exp_err));
    out_ready = 1'b1;
    step();
    check({tag, "_idle"}, DW'({in_ready, out_valid}), DW'(2'b10));
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] one;
    logic [DW-1:0] pat;
    logic [DW-1:0] held;
    ones      = '1;
    one       = 1;
    pat       = {64'hDEADBEEF_01234567, 64'h89ABCDEF_FEDCBA98, 64'h0F0F0F0F_F0F0F0F0,
                 64'h12345678_9ABCDEF0};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    A_in      = '0;
    B_in      = '0;

    // Reset state, with a transaction offered to show reset wins.
    step();
    in_valid = 1'b1;
    opcode   = 3'b001;
    A_in     = one;
    step();
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_err", DW'(out_err), DW'(0));
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
    check("post_rst_ready", DW'({in_ready, out_valid}), DW'(2'b10));

    run_op("pop_ones", 3'b011, ones, '0, DW'(256), 1'b0, 5);
    run_op("pop_0f", 3'b011, DW'(8'h0F), '0, DW'(4), 1'b0, 5);
    run_op("rotl_257", 3'b010, one, DW'(257), DW'(2), 1'b0, 2);
    run_op("rotr_1", 3'b001, one, DW'(1), one << 255, 1'b0, 2);
    run_op("rotl_0", 3'b010, pat, '0, pat, 1'b0, 2);
    run_op("rotr_4", 3'b001, DW'(16'hABCD), DW'(4), (one << 252) * 4'hD | DW'(12'hABC), 1'b0, 2);
    run_op("clz_0", 3'b100, '0, '0, DW'(256), 1'b0, 5);
    run_op("clz_msb", 3'b100, one << 255, '0, DW'(0), 1'b0, 5);
    run_op("clz_130", 3'b100, (one << 130) | one, '0, DW'(125), 1'b0, 5);
    run_op("ctz_100", 3'b101, one << 100, '0, DW'(100), 1'b0, 5);
    run_op("ctz_3", 3'b101, (one << 200) | (one << 3), '0, DW'(3), 1'b0, 5);
    run_op("ctz_0", 3'b101, '0, '0, DW'(256), 1'b0, 5);
    run_op("par_7", 3'b000, DW'(7), '0, DW'(1), 1'b0, 5);
    run_op("par_3", 3'b000, DW'(3), '0, DW'(0), 1'b0, 5);
    run_op("par_hi", 3'b000, one << 255, '0, DW'(1), 1'b0, 5);
    run_op("ill_110", 3'b110, ones, ones, '0, 1'b1, 2);
    run_op("ill_111", 3'b111, ones, '0, '0, 1'b1, 2);

    // Backpressure: hold the result for 6 cycles while busy-time in_valid pulses are offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = 3'b010;
    A_in      = DW'(8'hAB);
    B_in      = DW'(4);
    step();
    in_valid = 1'b0;
    step();
    check("bp_valid_rise", DW'(out_valid), DW'(1));
    held = out_data;
    check("bp_data", held, DW'(12'hAB0));
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      opcode   = 3'b011;
      A_in     = ones;
      step();
      check("bp_hold", DW'({out_valid, in_ready, out_err}), DW'(3'b100));
      check("bp_stable", out_data, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release", DW'({in_ready, out_valid}), DW'(2'b10));
    run_op("bp_next", 3'b001, DW'(2), DW'(1), DW'(1), 1'b0, 2);

    // Reset two cycles into a POPCOUNT run aborts it.
    in_valid = 1'b1;
    opcode   = 3'b011;
    A_in     = ones;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_rst_ready", DW'({in_ready, out_valid}), DW'(2'b00));
    rst = 1'b0;
    step();
    check("abort_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 6; i++) begin
      check("abort_no_valid", DW'(out_valid), DW'(0));
      step();
    end
    run_op("abort_par", 3'b000, one, '0, DW'(1), 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time guard.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bitop_unit.md
# bitop_unit

Parametrised, handshaked successor to the 256-bit bit-manipulation ALU. It accepts one operand pair per transaction over a valid/ready interface. Count-type operations (parity, popcount, CLZ, CTZ) run iteratively over CHUNK_WIDTH-bit slices, and rotates complete in a single cycle. It sits between the operand register file and the writeback stage, and supports backpressure on both sides.

## Interface
- DATA_WIDTH, 256: operand/result width; power of two, ≥ 8.
- CHUNK_WIDTH, 64: slice processed per RUN cycle; power of two, divides DATA_WIDTH. NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  unit can accept; high only in IDLE and not in reset.
- opcode  in  3  000 PARITY, 001 ROTR, 010 ROTL, 011 POPCOUNT, 100 CLZ, 101 CTZ, 110/111 illegal.
- A_in  in  DATA_WIDTH  operand.
- B_in  in  DATA_WIDTH  rotate amount; only low log2(DATA_WIDTH) bits used.
- out_valid  out  1  result held for consumer.
- out_ready  in  1  consumer takes result.
- out_data  out  DATA_WIDTH  result, zero-extended for count ops.
- out_err  out  1  qualifies out_data; 1 for illegal opcode.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. If in_valid, latch opcode, A_in and B_in, clear the accumulator and chunk index, then go to RUN.
  - RUN, rotates and illegal opcodes: one cycle, then DONE.
  - RUN, count ops: one chunk per cycle for exactly NCHUNK cycles, then DONE. No early termination.
  - DONE: out_valid=1. out_data and out_err are held stable until out_valid && out_ready, then go to IDLE.
- There is no IDLE bypass in DONE: a new transaction is accepted no earlier than the cycle after the handshake.
- Operation results:
  - PARITY: out_data[0] = XOR of all bits of A; upper bits are 0.
  - POPCOUNT: number of ones, 0..DATA_WIDTH. The accumulator is log2(DATA_WIDTH)+1 bits wide.
  - CLZ: chunks scanned MSB chunk first. Once a chunk contains a one, later chunks do not change the result. A=0 gives DATA_WIDTH.
  - CTZ: chunks scanned LSB chunk first, same rule. A=0 gives DATA_WIDTH.
  - ROTR/ROTL: rotate A by B mod DATA_WIDTH; amount 0 returns A unchanged.
  - Illegal opcode: out_data=0, out_err=1. Otherwise out_err=0.
- Operand registers are captured only on acceptance. Input changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_err 0, in_ready 0 during any cycle with rst=1.
- Latency, counted from the accepting edge to the edge where out_valid rises: rotates and illegal opcodes 2 edges; count ops NCHUNK+1 edges (5 at defaults).
- Throughput: at most one transaction per latency+1 cycles with out_ready held high.
- Backpressure: out_ready low in DONE holds out_valid, out_data and out_err stable indefinitely, with in_ready 0.
- in_valid while busy: ignored. The producer must hold it until in_ready.
- Reset mid-operation (RUN or DONE): the transaction is aborted and never produces out_valid. in_ready returns to 1 the first cycle after rst deasserts.
- Simultaneous rst and handshake: reset wins; the transaction is not accepted or delivered.

## Structure
- Package bitop_pkg holds:
  - the opcode localparams;
  - the FSM state enum (IDLE, RUN, DONE);
  - width helpers SHW = log2(DATA_WIDTH), CNTW = SHW+1 and IDXW = log2(NCHUNK).
- Sub-module bitop_chunk: combinational, parametrised on CHUNK_WIDTH. Outputs slice popcount, slice XOR, slice leading-zero count, slice trailing-zero count and a slice-nonzero flag. Instantiated once in the top.
- The rotator is a single barrel-rotate in the top (no sub-module).

## Test plan
Defaults throughout (DATA_WIDTH 256, CHUNK_WIDTH 64).
- POPCOUNT, A = all ones -> out_data = 256, out_err 0. out_valid rises 5 edges after acceptance. A = 0x0F -> 4.
- ROTL A=1, B=257 -> 2 (amount mod 256), 2-edge latency. ROTR A=1, B=1 -> only bit 255 set. ROTL B=0 -> A.
- CLZ A=0 -> 256. CLZ A=1<<255 -> 0. CTZ A=1<<100 -> 100. CTZ A=(1<<200)|(1<<3) -> 3.
- PARITY A=7 -> 1; A=3 -> 0. Opcode 110 -> out_data 0, out_err 1.
- Backpressure: out_ready low 6 cycles in DONE -> out_valid and out_data stable, in_ready 0, in_valid pulses ignored. Next accept occurs the cycle after the handshake.
- Reset after 2 RUN cycles of POPCOUNT -> out_valid stays 0. in_ready is 1 the cycle after rst deasserts, and a following PARITY A=1 returns 1.
